// File: rtl/rd_ptr_empty_ctrl_pkg.sv
// Shared async FIFO helpers: Gray/binary conversion and pointer sizing.
// Used by both the read-side empty controller and the write-side full controller.
package async_fifo_pkg;

    localparam int MAX_W = 32;

    function automatic int ptr_width(input int address_width);
        return address_width + 1;
    endfunction

    function automatic int fifo_depth(input int address_width);
        return 1 << address_width;
    endfunction

    // Callers slice the low bits they need; upper bits are zero for zero-extended input.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray,
                                                  input int             width);
        logic [MAX_W-1:0] bin;
        bin = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i == width - 1) begin
                bin[i] = gray[i];
            end else if (i < width - 1) begin
                bin[i] = bin[i+1] ^ gray[i];
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/rd_ptr_empty_ctrl_if.sv
// Read-side bus between the consumer/synchronizer and the read pointer controller.
// The slave modport is the controller's view.
interface rd_ptr_empty_ctrl_if
    import async_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4
);
    localparam int PTR_W = ptr_width(ADDRESS_WIDTH);

    logic                     rd_en;
    logic [PTR_W-1:0]         wr_ptr_gray_sync;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [PTR_W-1:0]         rd_ptr_gray;
    logic                     empty;
    logic                     almost_empty;
    logic [PTR_W-1:0]         fill_level;
    logic                     rd_valid;
    logic                     underflow;

    modport master (
        output rd_en,
        output wr_ptr_gray_sync,
        input  rd_addr,
        input  rd_ptr_gray,
        input  empty,
        input  almost_empty,
        input  fill_level,
        input  rd_valid,
        input  underflow
    );

    modport slave (
        input  rd_en,
        input  wr_ptr_gray_sync,
        output rd_addr,
        output rd_ptr_gray,
        output empty,
        output almost_empty,
        output fill_level,
        output rd_valid,
        output underflow
    );

endinterface

// File: rtl/rd_ptr_empty_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter, shared with the write-side full controller.
// Each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer and status controller for the async FIFO.
// Advances the read pointer and registers empty/almost_empty/fill/valid/underflow.
module rd_ptr_empty_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 4,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              s_rst,
    rd_ptr_empty_ctrl_if.slave bus
);

    localparam int PTR_W = ptr_width(ADDRESS_WIDTH);
    localparam logic [PTR_W-1:0] TH_C = PTR_W'(ALMOST_EMPTY_TH);

    logic [PTR_W-1:0] rd_bin_q,  rd_bin_d;
    logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0] fill_q,    fill_d;
    logic             empty_q,   empty_d;
    logic             aempty_q,  aempty_d;
    logic             valid_q,   valid_d;
    logic             uflow_q,   uflow_d;
    logic             rd_inc;
    logic [PTR_W-1:0] wr_bin_sync;
    logic [MAX_W-1:0] rd_gray_wide;

    fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_wr_gray2bin (
        .gray_i (bus.wr_ptr_gray_sync),
        .bin_o  (wr_bin_sync)
    );

    // Status is computed from the post-increment pointer so the flags line up
    // with the address the memory will see next cycle.
    always_comb begin
        rd_inc       = bus.rd_en & ~empty_q;
        rd_bin_d     = rd_bin_q + {{(PTR_W-1){1'b0}}, rd_inc};
        rd_gray_wide = bin2gray(MAX_W'(rd_bin_d));
        rd_gray_d    = rd_gray_wide[PTR_W-1:0];
        fill_d       = wr_bin_sync - rd_bin_d;
        empty_d      = (rd_gray_d == bus.wr_ptr_gray_sync);
        aempty_d     = (fill_d <= TH_C);
        valid_d      = rd_inc;
        uflow_d      = bus.rd_en & empty_q;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            fill_q    <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            valid_q   <= 1'b0;
            uflow_q   <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            fill_q    <= fill_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            valid_q   <= valid_d;
            uflow_q   <= uflow_d;
        end
    end

    assign bus.rd_addr      = rd_bin_q[ADDRESS_WIDTH-1:0];
    assign bus.rd_ptr_gray  = rd_gray_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = aempty_q;
    assign bus.fill_level   = fill_q;
    assign bus.rd_valid     = valid_q;
    assign bus.underflow    = uflow_q;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Self-checking bench for rd_ptr_empty_ctrl: a reference model fills a scoreboard
// each cycle, plus scenario-specific checks against known constants.
module tb_rd_ptr_empty_ctrl;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] gray;
        logic          empty;
        logic          aempty;
        logic [PW-1:0] fill;
        logic          valid;
        logic          uflow;
    } exp_t;

    logic clk;
    logic s_rst;
    logic [PW-1:0] wbin;

    logic [PW-1:0] m_rd;
    logic          m_empty;
    exp_t          sbq[$];

    int total;
    int bad;

    rd_ptr_empty_ctrl_if #(.ADDRESS_WIDTH(AW)) bus ();

    rd_ptr_empty_ctrl #(
        .ADDRESS_WIDTH   (AW),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .clk   (clk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: model predicts the post-edge state, then it is compared.
    task automatic drive_cycle(input logic rst, input logic en);
        exp_t          e;
        exp_t          g;
        logic [PW-1:0] wg;
        logic [PW-1:0] wb;
        logic [PW-1:0] nb;
        logic          inc;
        wg = wbin ^ (wbin >> 1);
        s_rst = rst;
        bus.rd_en = en;
        bus.wr_ptr_gray_sync = wg;
        wb = '0;
        for (int i = 0; i < PW; i++) wb = wb ^ (wg >> i);
        if (rst) begin
            e = '{addr: '0, gray: '0, empty: 1'b1, aempty: 1'b1, fill: '0, valid: 1'b0, uflow: 1'b0};
            m_rd = '0;
            m_empty = 1'b1;
        end else begin
            inc = en & ~m_empty;
            nb = m_rd + PW'(inc);
            e.addr   = nb[AW-1:0];
            e.gray   = nb ^ (nb >> 1);
            e.empty  = ((nb ^ (nb >> 1)) == wg);
            e.fill   = wb - nb;
            e.aempty = ((wb - nb) <= PW'(2));
            e.valid  = inc;
            e.uflow  = en & m_empty;
            m_rd = nb;
            m_empty = e.empty;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        total += 7;
        if (bus.rd_addr !== g.addr) begin
            bad++; $display("[TB] FAIL sb_rd_addr got=%0d exp=%0d", bus.rd_addr, g.addr);
        end
        if (bus.rd_ptr_gray !== g.gray) begin
            bad++; $display("[TB] FAIL sb_rd_ptr_gray got=%b exp=%b", bus.rd_ptr_gray, g.gray);
        end
        if (bus.empty !== g.empty) begin
            bad++; $display("[TB] FAIL sb_empty got=%b exp=%b", bus.empty, g.empty);
        end
        if (bus.almost_empty !== g.aempty) begin
            bad++; $display("[TB] FAIL sb_almost_empty got=%b exp=%b", bus.almost_empty, g.aempty);
        end
        if (bus.fill_level !== g.fill) begin
            bad++; $display("[TB] FAIL sb_fill_level got=%0d exp=%0d", bus.fill_level, g.fill);
        end
        if (bus.rd_valid !== g.valid) begin
            bad++; $display("[TB] FAIL sb_rd_valid got=%b exp=%b", bus.rd_valid, g.valid);
        end
        if (bus.underflow !== g.uflow) begin
            bad++; $display("[TB] FAIL sb_underflow got=%b exp=%b", bus.underflow, g.uflow);
        end
    endtask

    task automatic test_reset();
        wbin = '0;
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1);
        total++;
        if ({bus.empty, bus.almost_empty, bus.fill_level, bus.rd_addr, bus.rd_ptr_gray,
             bus.rd_valid, bus.underflow} !== {1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_state got e=%b ae=%b f=%0d a=%0d g=%b v=%b u=%b exp e=1 ae=1 f=0 a=0 g=0 v=0 u=0",
                     bus.empty, bus.almost_empty, bus.fill_level, bus.rd_addr, bus.rd_ptr_gray,
                     bus.rd_valid, bus.underflow);
        end
    endtask

    task automatic test_basic_read();
        wbin = 5'd3;
        drive_cycle(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.rd_addr !== 4'(k)) begin
                bad++; $display("[TB] FAIL basic_addr got=%0d exp=%0d", bus.rd_addr, k);
            end
            drive_cycle(1'b0, 1'b1);
            total++;
            if (bus.rd_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL basic_valid got=%b exp=1", bus.rd_valid);
            end
        end
        total++;
        if ({bus.empty, bus.rd_addr, bus.rd_ptr_gray} !== {1'b1, 4'd3, 5'b00010}) begin
            bad++;
            $display("[TB] FAIL basic_end got e=%b a=%0d g=%b exp e=1 a=3 g=00010",
                     bus.empty, bus.rd_addr, bus.rd_ptr_gray);
        end
        drive_cycle(1'b0, 1'b0);
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_valid_drop got=%b exp=0", bus.rd_valid);
        end
    endtask

    task automatic test_underflow();
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b1);
            total++;
            if ({bus.underflow, bus.rd_addr, bus.rd_valid} !== {1'b1, 4'd3, 1'b0}) begin
                bad++;
                $display("[TB] FAIL underflow_pulse got u=%b a=%0d v=%b exp u=1 a=3 v=0",
                         bus.underflow, bus.rd_addr, bus.rd_valid);
            end
        end
        drive_cycle(1'b0, 1'b0);
        total++;
        if (bus.underflow !== 1'b0) begin
            bad++; $display("[TB] FAIL underflow_clear got=%b exp=0", bus.underflow);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [4];
        seq = '{4'd14, 4'd15, 4'd0, 4'd1};
        wbin = 5'd30;
        drive_cycle(1'b0, 1'b0);
        repeat (27) drive_cycle(1'b0, 1'b1);
        total++;
        if ({bus.rd_addr, bus.empty, bus.rd_ptr_gray[4]} !== {4'd14, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL wrap_start got a=%0d e=%b msb=%b exp a=14 e=1 msb=1",
                     bus.rd_addr, bus.empty, bus.rd_ptr_gray[4]);
        end
        wbin = 5'd2;
        drive_cycle(1'b0, 1'b0);
        total++;
        if (bus.fill_level !== 5'd4) begin
            bad++; $display("[TB] FAIL wrap_fill4 got=%0d exp=4", bus.fill_level);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.rd_addr !== seq[k]) begin
                bad++; $display("[TB] FAIL wrap_addr got=%0d exp=%0d", bus.rd_addr, seq[k]);
            end
            drive_cycle(1'b0, 1'b1);
            total++;
            if (bus.fill_level !== 5'(3 - k)) begin
                bad++; $display("[TB] FAIL wrap_fill got=%0d exp=%0d", bus.fill_level, 3 - k);
            end
        end
        total++;
        if ({bus.empty, bus.rd_ptr_gray[4], bus.rd_addr} !== {1'b1, 1'b0, 4'd2}) begin
            bad++;
            $display("[TB] FAIL wrap_end got e=%b msb=%b a=%0d exp e=1 msb=0 a=2",
                     bus.empty, bus.rd_ptr_gray[4], bus.rd_addr);
        end
    endtask

    task automatic test_full();
        wbin = '0;
        drive_cycle(1'b1, 1'b0);
        wbin = 5'd16;
        drive_cycle(1'b0, 1'b0);
        total++;
        if ({bus.fill_level, bus.empty, bus.almost_empty} !== {5'd16, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL full_level got f=%0d e=%b ae=%b exp f=16 e=0 ae=0",
                     bus.fill_level, bus.empty, bus.almost_empty);
        end
    endtask

    task automatic test_threshold();
        wbin = '0;
        drive_cycle(1'b1, 1'b0);
        wbin = 5'd3;
        drive_cycle(1'b0, 1'b0);
        total++;
        if ({bus.fill_level, bus.almost_empty} !== {5'd3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL thresh_above got f=%0d ae=%b exp f=3 ae=0",
                     bus.fill_level, bus.almost_empty);
        end
        drive_cycle(1'b0, 1'b1);
        total++;
        if ({bus.fill_level, bus.almost_empty} !== {5'd2, 1'b1}) begin
            bad++;
            $display("[TB] FAIL thresh_at got f=%0d ae=%b exp f=2 ae=1",
                     bus.fill_level, bus.almost_empty);
        end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b0, 1'b1);
        wbin = 5'd4;
        drive_cycle(1'b0, 1'b1);
        total++;
        if ({bus.empty, bus.fill_level} !== {1'b0, 5'd1}) begin
            bad++;
            $display("[TB] FAIL simul_new_wr got e=%b f=%0d exp e=0 f=1", bus.empty, bus.fill_level);
        end
        drive_cycle(1'b0, 1'b1);
        total++;
        if ({bus.empty, bus.fill_level} !== {1'b1, 5'd0}) begin
            bad++;
            $display("[TB] FAIL simul_last got e=%b f=%0d exp e=1 f=0", bus.empty, bus.fill_level);
        end
    endtask

    task automatic test_back_to_back();
        wbin = 5'd9;
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1);
        total++;
        if ({bus.rd_valid, bus.rd_addr} !== {1'b1, 4'd6}) begin
            bad++;
            $display("[TB] FAIL b2b_reads got v=%b a=%0d exp v=1 a=6", bus.rd_valid, bus.rd_addr);
        end
        drive_cycle(1'b1, 1'b1);
        total++;
        if ({bus.rd_valid, bus.rd_addr, bus.empty, bus.fill_level} !== {1'b0, 4'd0, 1'b1, 5'd0}) begin
            bad++;
            $display("[TB] FAIL b2b_mid_reset got v=%b a=%0d e=%b f=%0d exp v=0 a=0 e=1 f=0",
                     bus.rd_valid, bus.rd_addr, bus.empty, bus.fill_level);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_rd = '0;
        m_empty = 1'b1;
        s_rst = 1'b1;
        bus.rd_en = 1'b0;
        bus.wr_ptr_gray_sync = '0;
        wbin = '0;
        #2;
        test_reset();
        test_basic_read();
        test_underflow();
        test_wrap();
        test_full();
        test_threshold();
        test_simultaneous();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
